// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the memory port arbiter: MEM-stage
//               operation codes, arbiter FSM state codes and stall-vector
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   // MEM-stage operation codes carried by the EX/MEM register
   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_e;

   // Arbiter FSM state codes
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUS_IF  = 2'd1,
      ST_BUS_MEM = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_e;

   // Stall request vector bit positions
   localparam int c_STALL_PC     = 0;
   localparam int c_STALL_IF_ID  = 1;
   localparam int c_STALL_ID_EX  = 2;
   localparam int c_STALL_EX_MEM = 3;
   localparam int c_STALL_MEM_WB = 4;
   localparam int c_STALL_RSVD   = 5;
   localparam int c_STALL_WIDTH  = 6;

   // True for the three store operations
   function automatic logic op_is_store(input logic [3:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane logic for the shared memory port.
//               Request side: misalignment check, byte enables and store
//               data replication. Response side: load lane extraction with
//               sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [3:0]  req_op_i,
   input  logic [1:0]  req_addr_lo_i,
   input  logic [31:0] req_wdata_i,
   output logic        req_misalign_o,
   output logic        req_we_o,
   output logic [3:0]  req_be_o,
   output logic [31:0] req_wdata_o,
   input  logic [3:0]  rsp_op_i,
   input  logic [1:0]  rsp_addr_lo_i,
   input  logic [31:0] rsp_rdata_i,
   output logic [31:0] rsp_data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halfwords need an even address, words need a four-byte boundary
   always_comb begin
      req_misalign_o = 1'b0;
      case (req_op_i)
         MEM_LH, MEM_LHU, MEM_SH: req_misalign_o = req_addr_lo_i[0];
         MEM_LW, MEM_SW:          req_misalign_o = |req_addr_lo_i;
         default:                 req_misalign_o = 1'b0;
      endcase
   end

   // Stores replicate the datum across every lane and enable only the
   // addressed lanes; loads always read the full word
   always_comb begin
      req_we_o    = 1'b0;
      req_be_o    = 4'b1111;
      req_wdata_o = '0;
      case (req_op_i)
         MEM_SB: begin
            req_we_o    = 1'b1;
            req_be_o    = 4'b0001 << req_addr_lo_i;
            req_wdata_o = {4{req_wdata_i[7:0]}};
         end
         MEM_SH: begin
            req_we_o    = 1'b1;
            req_be_o    = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
            req_wdata_o = {2{req_wdata_i[15:0]}};
         end
         MEM_SW: begin
            req_we_o    = 1'b1;
            req_be_o    = 4'b1111;
            req_wdata_o = req_wdata_i;
         end
         default: begin
            req_we_o    = 1'b0;
            req_be_o    = 4'b1111;
            req_wdata_o = '0;
         end
      endcase
   end

   // Pick the addressed lane out of the returned word
   always_comb begin
      w_byte = rsp_rdata_i[7:0];
      case (rsp_addr_lo_i)
         2'd0:    w_byte = rsp_rdata_i[7:0];
         2'd1:    w_byte = rsp_rdata_i[15:8];
         2'd2:    w_byte = rsp_rdata_i[23:16];
         default: w_byte = rsp_rdata_i[31:24];
      endcase
      w_half = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
   end

   // Extend the extracted lane to a full register value
   always_comb begin
      rsp_data_o = rsp_rdata_i;
      case (rsp_op_i)
         MEM_LB:  rsp_data_o = {{24{w_byte[7]}}, w_byte};
         MEM_LBU: rsp_data_o = {24'h000000, w_byte};
         MEM_LH:  rsp_data_o = {{16{w_half[15]}}, w_half};
         MEM_LHU: rsp_data_o = {16'h0000, w_half};
         default: rsp_data_o = rsp_rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates the single shared memory port between instruction
//               fetch and the MEM stage. Holds the bus request stable across
//               slave wait states, steers byte lanes, extends loads, flags
//               misaligned accesses and drives the pipeline stall vector.
//               Optional macro ARB_FAIR_EN: alternate grants between MEM and
//               IF under contention instead of strict MEM priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_data_o,
   output logic                  if_ack_o,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic [DATA_WIDTH-1:0] mem_rdata_o,
   output logic                  mem_ack_o,
   output logic                  misalign_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wdata_o,
   output logic [3:0]            bus_be_o,
   input  logic [DATA_WIDTH-1:0] bus_rdata_i,
   input  logic                  bus_ack_i,
   output logic [5:0]            stall_o
);

   arb_state_e r_state;
   arb_state_e w_next_state;

   logic       w_mem_valid;
   logic       w_mem_first;
   logic       w_fair_yield;
   logic       w_grant_if;
   logic       w_grant_mem;
   logic       w_done_if;
   logic       w_done_mem;
   logic       w_misalign_ack;

   logic       w_misalign;
   logic       w_store_we;
   logic [3:0] w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata_ext;

   // Op and byte offset of the MEM access in flight, used to extract the
   // load result when the slave responds
   logic [3:0] r_op;
   logic [1:0] r_addr_lo;

   // Fetch addresses are word aligned, so their low bits carry no information
   logic w_if_addr_lo_unused;
   assign w_if_addr_lo_unused = &{1'b0, if_addr_i[1:0]};

   assign w_mem_valid = (mem_op_i != MEM_NOP);

`ifdef ARB_FAIR_EN
   logic r_last_mem;

   // Remember whether the most recent completion served the MEM stage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_mem <= 1'b0;
      end else if (w_done_mem || w_misalign_ack) begin
         r_last_mem <= 1'b1;
      end else if (w_done_if) begin
         r_last_mem <= 1'b0;
      end
   end

   assign w_fair_yield = r_last_mem & if_req_i;
`else
   assign w_fair_yield = 1'b0;
`endif

   assign w_mem_first = w_mem_valid & ~w_fair_yield;

   mem_lane_align u_lane_align (
      .req_op_i       (mem_op_i),
      .req_addr_lo_i  (mem_addr_i[1:0]),
      .req_wdata_i    (mem_data_i),
      .req_misalign_o (w_misalign),
      .req_we_o       (w_store_we),
      .req_be_o       (w_be),
      .req_wdata_o    (w_wdata),
      .rsp_op_i       (r_op),
      .rsp_addr_lo_i  (r_addr_lo),
      .rsp_rdata_i    (bus_rdata_i),
      .rsp_data_o     (w_rdata_ext)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and grant/completion decode; DONE never grants so the MEM op
   // still visible during its ack cycle is not issued a second time
   always_comb begin
      w_next_state   = r_state;
      w_grant_if     = 1'b0;
      w_grant_mem    = 1'b0;
      w_done_if      = 1'b0;
      w_done_mem     = 1'b0;
      w_misalign_ack = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_first) begin
               if (w_misalign) begin
                  w_misalign_ack = 1'b1;
                  w_next_state   = ST_DONE;
               end else begin
                  w_grant_mem  = 1'b1;
                  w_next_state = ST_BUS_MEM;
               end
            end else if (if_req_i) begin
               w_grant_if   = 1'b1;
               w_next_state = ST_BUS_IF;
            end
         end
         ST_BUS_IF: begin
            if (bus_ack_i) begin
               w_done_if    = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_BUS_MEM: begin
            if (bus_ack_i) begin
               w_done_mem   = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Bus request attributes, completion pulses and captured response data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         if_data_o   <= '0;
         if_ack_o    <= 1'b0;
         mem_rdata_o <= '0;
         mem_ack_o   <= 1'b0;
         misalign_o  <= 1'b0;
         r_op        <= '0;
         r_addr_lo   <= '0;
      end else begin
         if_ack_o   <= 1'b0;
         mem_ack_o  <= 1'b0;
         misalign_o <= 1'b0;

         if (w_grant_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= w_store_we;
            bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata_o <= w_wdata;
            bus_be_o    <= w_be;
            r_op        <= mem_op_i;
            r_addr_lo   <= mem_addr_i[1:0];
         end

         if (w_grant_if) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata_o <= '0;
            bus_be_o    <= 4'b1111;
         end

         if (w_done_if || w_done_mem) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_be_o  <= '0;
         end

         if (w_done_if) begin
            if_ack_o  <= 1'b1;
            if_data_o <= bus_rdata_i;
         end

         if (w_done_mem) begin
            mem_ack_o   <= 1'b1;
            mem_rdata_o <= w_rdata_ext;
         end

         if (w_misalign_ack) begin
            mem_ack_o   <= 1'b1;
            misalign_o  <= 1'b1;
            mem_rdata_o <= '0;
         end
      end
   end

   // Stall request: a pending MEM op freezes the front four stages, a
   // pending fetch freezes PC and IF/ID
   always_comb begin
      stall_o = '0;
      if (w_mem_valid && !mem_ack_o) begin
         stall_o[c_STALL_PC]     = 1'b1;
         stall_o[c_STALL_IF_ID]  = 1'b1;
         stall_o[c_STALL_ID_EX]  = 1'b1;
         stall_o[c_STALL_EX_MEM] = 1'b1;
      end
      if (if_req_i && !if_ack_o) begin
         stall_o[c_STALL_PC]    = 1'b1;
         stall_o[c_STALL_IF_ID] = 1'b1;
      end
      stall_o[c_STALL_MEM_WB] = 1'b0;
      stall_o[c_STALL_RSVD]   = 1'b0;
   end

endmodule
`default_nettype wire
